uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares one UART transmit serializer among `NUM_REQ` requesters. Each requester presents a byte and holds `req`. The block grants one requester at a time, latches its byte and serializes it on `tx` as start, data (LSB first), optional parity and stop bits. Bit timing matches the receiver's `SAMPLE` counter. It sits between on-chip byte producers and the single `tx` pin.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SAMPLE`, 52: bit period is `SAMPLE+1` clocks (counter 0..SAMPLE).
- `DATA_BITS`, 8: data bits per frame.
- `STOP_BITS`, 2: stop bits per frame (1..2).
- `Clk` in 1: single clock; all logic on posedge.
- `Rst_n` in 1: reset, synchronous, active-low.
- `req` in NUM_REQ: per-requester request, level; held until `gnt`.
- `data_in` in NUM_REQ*DATA_BITS: requester i byte at `[i*DATA_BITS +: DATA_BITS]`.
- `gnt` out NUM_REQ: one-hot, one-cycle pulse; byte latched on this cycle.
- `done` out NUM_REQ: one-hot, one-cycle pulse on the last cycle of the last stop bit.
- `owner` out clog2(NUM_REQ): index of the current or last granted requester.
- `busy` out 1: high from the cycle after `gnt` until the cycle after `done`.
- `tx` out 1: serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset values: `tx`=1, `gnt`=0, `done`=0, `busy`=0, `owner`=0, state IDLE, counters 0. The priority pointer is set so requester 0 wins first.
- IDLE: if any `req` is set, grant the first set bit searching from `owner+1` modulo NUM_REQ. Pulse `gnt[i]`, latch `data_in` slice i into the shift register, set `owner`=i, go to START. With no `req`, stay in IDLE.
- START: `tx`=0 for one bit period, then go to DATA.
- DATA: `tx`=shift[0], shifting right each period for DATA_BITS periods. A bit index counter runs 0..DATA_BITS-1.
- STOP: `tx`=1 for STOP_BITS periods. `done[owner]` pulses on the final clock of the last period; the next state is IDLE.
- Bit counter: 7 bits wide, clears on state entry. A period ends when counter==SAMPLE.
- `req` deasserting after `gnt` has no effect. `req` still high after `done` is treated as a new request. The requester must drop `req` in the `gnt` cycle to avoid resending.
- Simultaneous requests: exactly one grant per frame. Rotation guarantees every active requester is granted within NUM_REQ frames.
- `data_in` changes after `gnt` do not affect the frame in flight.
- Reset asserted mid-frame: on the next edge `tx`=1 and all outputs return to reset values. The frame is aborted and no `done` is issued.

## Timing
- `gnt` at cycle T (IDLE, req seen). `tx` falls at T+1.
- Frame length is F=(1+DATA_BITS+P+STOP_BITS)*(SAMPLE+1) clocks, P=1 with the macro, else 0. `done` at T+F, IDLE at T+F+1.
- Earliest next `gnt` is at T+F+1, so frames are separated by one idle cycle of `tx`=1.
- `busy` is high for cycles T+1..T+F.
- `tx` is registered; there is no combinational path from `req` or `data_in` to `tx`.

## Configuration
- `UART_TX_SCHED_PARITY_EN` defined: PARITY state is inserted after DATA for one bit period. `tx` carries even parity (XOR of the latched data bits), and F grows by SAMPLE+1.
- Not defined: no PARITY state; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - default SAMPLE, DATA_BITS and STOP_BITS;
  - the receiver may reuse the same constants.
- Sub-module `uart_tx_core`: the serializer (state machine, bit counter, shift register, `tx`), with a `load`/`byte`/`frame_done` interface.
- `uart_tx_sched` holds the round-robin arbiter, the `owner` register and the `gnt`/`done` decode.

## Test plan
All scenarios use SAMPLE=3, so one bit period is 4 clocks.
- Single request: req[2]=1, data 0xA5 → `gnt`=0100 for one cycle. `tx` carries start 0, then 1,0,1,0,0,1,0,1, then 1,1, each bit held 4 clocks. `done[2]` pulses 44 clocks after `gnt`.
- Simultaneous: all `req`=1111 held high → grant order 0,1,2,3,0. Each `gnt` is 45 clocks apart.
- Fairness: req[0] held high, req[3] asserted once → req[3] is granted in the frame immediately after the current one.
- Data stability: `data_in` changed the cycle after `gnt` → the transmitted bits equal the latched byte.
- Reset mid-frame: `Rst_n`=0 during DATA bit 3 → next edge `tx`=1, `busy`=0, no `done`. After release, req 0 is granted first.
- Parity build: data 0x07 → parity bit 1 after the data bits. `done` comes 48 clocks after `gnt`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and default frame timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the matching receiver may import the same constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int DEF_SAMPLE    = 52;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 2;
  localparam int CNT_W         = 7;

  // Clocks from grant to the done pulse for one frame.
  function automatic int frame_clocks(input int sample, input int data_bits,
                                      input int parity, input int stop_bits);
    return (1 + data_bits + parity + stop_bits) * (sample + 1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle of the shared UART transmitter: requests, bytes, grants and line.
// Latency: n/a (wiring only).
// Backpressure: req is held until gnt; gnt/done are single-cycle pulses.
interface uart_tx_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] data_in;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic [IW-1:0]                owner;
  logic                         busy;
  logic                         tx;

  modport master (output req, data_in, input gnt, done, owner, busy, tx);
  modport slave  (input req, data_in, output gnt, done, owner, busy, tx);
endinterface

// File: rtl/uart_tx_core.sv
// UART serializer: start, LSB-first data, optional even parity (UART_TX_SCHED_PARITY_EN), stop bits.
// Latency: tx falls the cycle after load; frame_done on the last clock of the last stop bit.
// Backpressure: load is only honoured while idle; busy is high for the whole frame.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int SAMPLE    = DEF_SAMPLE,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = $clog2(BMAX + 1);

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 period_end;
  logic                 last_data;
  logic                 last_stop;

  assign period_end = (cnt_q == CNT_W'(SAMPLE));
  assign last_data  = (bit_q == BW'(DATA_BITS - 1));
  assign last_stop  = (bit_q == BW'(STOP_BITS - 1));
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);

  // Next state, bit timing and the registered value of the line.
  always_comb begin
    state_d    = state_q;
    cnt_d      = period_end ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (load) begin
          state_d = ST_START;
          shift_d = tx_byte;
          par_d   = ^tx_byte;
        end
      end
      ST_START: begin
        if (period_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          if (last_data) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (period_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (period_end) begin
          if (last_stop) begin
            state_d    = ST_IDLE;
            bit_d      = '0;
            frame_done = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Serializer registers; reset aborts any frame and returns the line to idle high.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART serializer among NUM_REQ byte producers (parity via UART_TX_SCHED_PARITY_EN).
// Latency: gnt in the idle cycle req is seen, tx falls next cycle, done F clocks after gnt.
// Backpressure: one grant per frame; req is held until gnt, next grant one cycle after done.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SAMPLE    = DEF_SAMPLE,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input logic           Clk,
  input logic           Rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          found;
  logic          core_busy;
  logic          frame_done;
  logic          load;

  // First pending request at or after the rotating pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Reset gating keeps gnt quiet while reset is held.
  assign load      = found && !core_busy && Rst_n;
  assign bus.gnt   = load ? (NUM_REQ'(1) << sel) : '0;
  assign bus.done  = frame_done ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.owner = owner_q;
  assign bus.busy  = core_busy;

  // Owner and priority pointer advance on every grant; pointer starts at requester 0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else if (load) begin
      owner_q <= sel;
      ptr_q   <= IW'((int'(sel) + 1) % NUM_REQ);
    end
  end

  uart_tx_core #(
    .SAMPLE    (SAMPLE),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) u_core (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load       (load),
    .tx_byte    (bus.data_in[sel*DATA_BITS +: DATA_BITS]),
    .tx         (bus.tx),
    .busy       (core_busy),
    .frame_done (frame_done)
  );

endmodule
